// File: rtl/screen_mem_arbiter_if.sv
// screen_mem_arbiter_if: CPU, display and memory-array signals of the screen memory arbiter.
interface screen_mem_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_err;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_ack;
   logic [DATA_W-1:0] disp_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, mem_rdata,
      output cpu_ack, cpu_rdata, cpu_err, disp_ack, disp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, mem_rdata,
      input  cpu_ack, cpu_rdata, cpu_err, disp_ack, disp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/screen_mem_arbiter.sv
// screen_mem_arbiter: shares one single-port RAM between CPU and display scan-out, display-first with a CPU starvation guard.
// Defining ARB_STATS_EN adds grant counters and a longest-CPU-wait statistic.
module screen_mem_arbiter #(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 16,
   parameter int MEM_DEPTH    = 24576,
   parameter int MAX_DISP_RUN = 4
) (
   input  logic clk,
   input  logic rst_n,
   screen_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
   ,
   output logic [15:0] stat_cpu_grants,
   output logic [15:0] stat_disp_grants,
   output logic [7:0]  stat_cpu_wait_max
`endif
);
   localparam int RUN_W = $clog2(MAX_DISP_RUN + 1);
   localparam int AW1 = ADDR_W + 1;
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DISP_RUN);
   localparam logic [ADDR_W:0] DEPTH = AW1'(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DISP} owner_t;

   state_t            state, state_n;
   owner_t            owner;
   logic [RUN_W-1:0]  run_cnt;
   logic              lat_we, lat_oor, grant, cpu_win;
   logic [ADDR_W-1:0] lat_addr, sel_addr;
   logic [DATA_W-1:0] lat_wdata, cpu_rdata_q, disp_rdata_q;

   always_comb begin
      cpu_win        = bus.cpu_req && (!bus.disp_req || run_cnt == RUN_MAX);
      grant          = state == IDLE && (bus.cpu_req || bus.disp_req);
      sel_addr       = cpu_win ? bus.cpu_addr : bus.disp_addr;
      state_n        = state;
      bus.mem_en     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.cpu_ack    = 1'b0;
      bus.cpu_err    = 1'b0;
      bus.disp_ack   = 1'b0;
      bus.cpu_rdata  = cpu_rdata_q;
      bus.disp_rdata = disp_rdata_q;
      case (state)
         IDLE: state_n = grant ? ACCESS : IDLE;
         ACCESS: begin
            state_n       = RESP;
            bus.mem_en    = !lat_oor;
            bus.mem_we    = lat_we && !lat_oor;
            bus.mem_addr  = lat_addr;
            bus.mem_wdata = lat_wdata;
         end
         RESP: begin
            state_n      = IDLE;
            bus.cpu_ack  = owner == OWN_CPU;
            bus.cpu_err  = owner == OWN_CPU && lat_oor;
            bus.disp_ack = owner == OWN_DISP;
            // out-of-range CPU reads keep the held value; display reads return zero
            bus.cpu_rdata  = (owner == OWN_CPU && !lat_we && !lat_oor) ? bus.mem_rdata : cpu_rdata_q;
            bus.disp_rdata = owner == OWN_DISP ? (lat_oor ? '0 : bus.mem_rdata) : disp_rdata_q;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= OWN_NONE;
         run_cnt      <= '0;
         lat_we       <= 1'b0;
         lat_oor      <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         cpu_rdata_q  <= '0;
         disp_rdata_q <= '0;
      end else begin
         state        <= state_n;
         cpu_rdata_q  <= bus.cpu_rdata;
         disp_rdata_q <= bus.disp_rdata;
         if (grant) begin
            owner     <= cpu_win ? OWN_CPU : OWN_DISP;
            lat_we    <= cpu_win && bus.cpu_we;
            lat_addr  <= sel_addr;
            lat_wdata <= cpu_win ? bus.cpu_wdata : '0;
            lat_oor   <= {1'b0, sel_addr} >= DEPTH;
            run_cnt   <= (cpu_win || !bus.cpu_req) ? '0 : (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
         end
      end
   end

`ifdef ARB_STATS_EN
   logic [7:0] wait_cnt, wait_n;

   assign wait_n = wait_cnt + {7'd0, wait_cnt != 8'hFF};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cpu_grants   <= '0;
         stat_disp_grants  <= '0;
         stat_cpu_wait_max <= '0;
         wait_cnt          <= '0;
      end else begin
         if (grant && cpu_win) stat_cpu_grants <= stat_cpu_grants + 16'd1;
         if (grant && !cpu_win) stat_disp_grants <= stat_disp_grants + 16'd1;
         if (state == IDLE && bus.cpu_req && !cpu_win) begin
            wait_cnt <= wait_n;
            if (wait_n > stat_cpu_wait_max) stat_cpu_wait_max <= wait_n;
         end else if (grant && cpu_win) begin
            wait_cnt <= '0;
         end
      end
   end
`endif
endmodule

// File: tb/tb_screen_mem_arbiter.sv
// tb_screen_mem_arbiter: scoreboard bench for screen_mem_arbiter with a behavioural 1-cycle RAM.
module tb_screen_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic pre_en = 1'b0;
   logic [14:0] pre_addr = '0;
   logic [15:0] pre_data = '0;
   logic [15:0] tb_mem [0:24575] = '{default: 16'h0};
   logic [15:0] exp_q [$];
   int n_cmp = 0;
   int n_bad = 0;

   screen_mem_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

`ifdef ARB_STATS_EN
   logic [15:0] stat_cpu_grants, stat_disp_grants;
   logic [7:0]  stat_cpu_wait_max;
   screen_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .stat_cpu_grants(stat_cpu_grants), .stat_disp_grants(stat_disp_grants),
      .stat_cpu_wait_max(stat_cpu_wait_max)
   );
`else
   screen_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_en) tb_mem[pre_addr] = pre_data;
      if (bus.mem_en && bus.mem_addr < 15'd24576) begin
         if (bus.mem_we) tb_mem[bus.mem_addr] = bus.mem_wdata;
         else bus.mem_rdata <= tb_mem[bus.mem_addr];
      end
   end

   task automatic do_cpu(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                         output int lat, output int en_cnt, output logic err, output logic [15:0] rd);
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
      lat = -1; en_cnt = 0; err = 1'b0; rd = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.mem_en) en_cnt++;
         if (bus.cpu_ack) begin
            lat = i; err = bus.cpu_err; rd = bus.cpu_rdata;
            break;
         end
      end
      bus.cpu_req = 1'b0;
   endtask

   task automatic do_disp(input logic [14:0] addr, output int lat, output int en_cnt,
                          output logic [15:0] rd, output int cpu_seen);
      @(negedge clk);
      bus.disp_req = 1'b1; bus.disp_addr = addr;
      lat = -1; en_cnt = 0; rd = '0; cpu_seen = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.mem_en) en_cnt++;
         if (bus.cpu_ack) cpu_seen++;
         if (bus.disp_ack) begin
            lat = i; rd = bus.disp_rdata;
            break;
         end
      end
      bus.disp_req = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] o [6];
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.disp_req = 1'b0; bus.disp_addr = '0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      o = '{16'(bus.mem_en), 16'(bus.cpu_ack), 16'(bus.disp_ack), 16'(bus.cpu_err), bus.cpu_rdata, bus.disp_rdata};
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (o[i] !== 16'h0) begin
            n_bad++; $display("FAIL reset_out%0d: got %0h expected 0", i, o[i]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_cpu_rw();
      int lat, en; logic err; logic [15:0] rd;
      exp_q.push_back(16'h5555);
      do_cpu(1'b1, 15'h0003, 16'h5555, lat, en, err, rd);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d expected 2", lat); end
      n_cmp++; if (en !== 1) begin n_bad++; $display("FAIL wr_mem_en_cycles: got %0d expected 1", en); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %0b expected 0", err); end
      do_cpu(1'b0, 15'h0003, 16'h0, lat, en, err, rd);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d expected 2", lat); end
      n_cmp++; if (en !== 1) begin n_bad++; $display("FAIL rd_mem_en_cycles: got %0d expected 1", en); end
      n_cmp++; if (rd !== exp_q[0]) begin n_bad++; $display("FAIL rd_data: got %0h expected %0h", rd, exp_q[0]); end
      void'(exp_q.pop_front());
   endtask

   task automatic test_display();
      logic [15:0] vals [4] = '{16'h00FF, 16'h0F0F, 16'h3333, 16'h5555};
      int lat, en, cs, cpu_total; logic [15:0] rd, e;
      cpu_total = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pre_en = 1'b1; pre_addr = 15'h4000 + 15'(i); pre_data = vals[i];
      end
      @(negedge clk);
      pre_en = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(vals[i]);
      for (int i = 0; i < 4; i++) begin
         do_disp(15'h4000 + 15'(i), lat, en, rd, cs);
         cpu_total += cs;
         e = exp_q.pop_front();
         n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL disp_data%0d: got %0h expected %0h", i, rd, e); end
         n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL disp_latency%0d: got %0d expected 2", i, lat); end
      end
      n_cmp++; if (cpu_total !== 0) begin n_bad++; $display("FAIL disp_no_cpu_ack: got %0d expected 0", cpu_total); end
   endtask

   task automatic test_priority();
      logic order_q [$];
      logic e;
      int acks = 0;
      repeat (4) order_q.push_back(1'b0);
      order_q.push_back(1'b1);
      order_q.push_back(1'b0);
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0003;
      bus.disp_req = 1'b1; bus.disp_addr = 15'h4000;
      for (int i = 0; i < 60 && acks < 6; i++) begin
         @(negedge clk);
         if (bus.cpu_ack || bus.disp_ack) begin
            e = order_q.pop_front();
            n_cmp++;
            if (bus.cpu_ack !== e) begin
               n_bad++; $display("FAIL grant_order%0d: got cpu=%0b expected cpu=%0b", acks, bus.cpu_ack, e);
            end
            if (bus.cpu_ack) begin
               n_cmp++;
               if (bus.cpu_rdata !== 16'h5555) begin
                  n_bad++; $display("FAIL prio_cpu_data: got %0h expected 5555", bus.cpu_rdata);
               end
               bus.cpu_req = 1'b0;
            end
            acks++;
            if (acks == 6) bus.disp_req = 1'b0;
         end
      end
      bus.cpu_req = 1'b0; bus.disp_req = 1'b0;
      n_cmp++; if (acks !== 6) begin n_bad++; $display("FAIL prio_ack_count: got %0d expected 6", acks); end
   endtask

   task automatic test_out_of_range();
      int lat, en, cs; logic err; logic [15:0] rd, e;
      exp_q.push_back(16'h5555);
      do_cpu(1'b0, 15'h6000, 16'h0, lat, en, err, rd);
      e = exp_q.pop_front();
      n_cmp++; if (en !== 0) begin n_bad++; $display("FAIL oor_mem_en: got %0d expected 0", en); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL oor_latency: got %0d expected 2", lat); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %0b expected 1", err); end
      n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL oor_rdata_hold: got %0h expected %0h", rd, e); end
      exp_q.push_back(16'h0000);
      do_disp(15'h7000, lat, en, rd, cs);
      e = exp_q.pop_front();
      n_cmp++; if (en !== 0) begin n_bad++; $display("FAIL oor_disp_mem_en: got %0d expected 0", en); end
      n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL oor_disp_data: got %0h expected %0h", rd, e); end
   endtask

   task automatic test_reset_mid_access();
      int lat, en, acks; logic err; logic [15:0] rd;
      acks = 0;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0010; bus.cpu_wdata = 16'hAAAA;
      @(negedge clk);
      n_cmp++; if (bus.mem_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_access: got %0b expected 1", bus.mem_en); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_async_en: got %0b expected 0", bus.mem_en); end
      bus.cpu_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.cpu_ack) acks++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (bus.cpu_ack) acks++;
      end
      n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rstmid_no_ack: got %0d expected 0", acks); end
      exp_q.push_back(16'h0000);
      do_cpu(1'b0, 15'h0010, 16'h0, lat, en, err, rd);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rstmid_next_latency: got %0d expected 2", lat); end
      n_cmp++; if (rd !== exp_q[0]) begin n_bad++; $display("FAIL rstmid_lost_write: got %0h expected %0h", rd, exp_q[0]); end
      void'(exp_q.pop_front());
   endtask

`ifdef ARB_STATS_EN
   task automatic test_stats();
      int lat, en, cs; logic err; logic [15:0] rd;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (3) do_cpu(1'b0, 15'h0003, 16'h0, lat, en, err, rd);
      repeat (5) do_disp(15'h4000, lat, en, rd, cs);
      @(negedge clk);
      n_cmp++; if (stat_cpu_grants !== 16'd3) begin n_bad++; $display("FAIL stat_cpu: got %0d expected 3", stat_cpu_grants); end
      n_cmp++; if (stat_disp_grants !== 16'd5) begin n_bad++; $display("FAIL stat_disp: got %0d expected 5", stat_disp_grants); end
      n_cmp++; if (stat_cpu_wait_max !== 8'd0) begin n_bad++; $display("FAIL stat_wait: got %0d expected 0", stat_cpu_wait_max); end
   endtask
`endif

   initial begin
      test_reset();
      test_cpu_rw();
      test_display();
      test_priority();
      test_out_of_range();
      test_reset_mid_access();
`ifdef ARB_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
